puf_eval_ctrl: RTL and testbench
================================

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameter line_length, default 64: challenge width; SHALL be 32 or 64.
REQ-002 Parameter SETTLE_CYCLES, default 8: launch-high and launch-low dwell per vote; SHALL be >= 3.
REQ-003 Parameter VOTES, default 15: evaluations per response; SHALL be odd, 1..255.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 seed  input  line_length  LFSR seed value.
REQ-007 seed_load  input  1  loads seed into the LFSR.
REQ-008 start  input  1  requests one response evaluation.
REQ-009 arb_resp  input  1  raw arbiter output from the delay line; asynchronous to clk.
REQ-010 challenge  output  line_length  challenge bits driven to the delay line.
REQ-011 launch  output  1  race pulse driven into the delay line.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_bit  output  1  majority-voted response bit.
REQ-015 resp_ready  input  1  consumer accepts the response.

Function
REQ-016 FSM states SHALL be IDLE, FIRE, SAMPLE, REST, DONE; all outputs SHALL be registered.
REQ-017 arb_resp SHALL pass through a 2-flop synchronizer before any use.
REQ-018 IDLE: start=1 -> FIRE next cycle. Vote counter and ones counter SHALL clear at that transition.
REQ-019 FIRE: launch=1 for exactly SETTLE_CYCLES cycles -> SAMPLE.
REQ-020 SAMPLE: one cycle, launch=1. The synchronized arb_resp SHALL be captured and ones counter incremented when it is 1 -> REST.
REQ-021 REST: launch=0 for SETTLE_CYCLES cycles. Then FIRE if votes done < VOTES, else DONE.
REQ-022 Start-to-valid latency SHALL be exactly 1 + VOTES*(2*SETTLE_CYCLES+1) cycles (256 at defaults).
REQ-023 DONE: resp_valid=1. resp_bit = (ones > VOTES/2, integer division). Both SHALL hold stable until resp_valid & resp_ready.
REQ-024 On a resp_valid & resp_ready edge: go to IDLE and advance the LFSR one step. resp_ready asserted outside DONE SHALL be ignored.
REQ-025 challenge SHALL equal the LFSR state and SHALL NOT change from start acceptance until the handshake completes.
REQ-026 LFSR SHALL be Fibonacci, left shift, feedback into bit 0.
  - line_length=64: taps 64,63,61,60.
  - line_length=32: taps 32,22,2,1.
REQ-027 seed_load SHALL take effect only in IDLE and SHALL have priority over start in the same cycle; start SHALL then be ignored.
REQ-028 A zero seed SHALL load as all-ones; the LFSR SHALL never hold zero.
REQ-029 start held high in DONE SHALL be ignored; a new evaluation needs start sampled high in IDLE.
REQ-030 Ones counter SHALL be 8 bits wide and SHALL NOT wrap (VOTES <= 255).

Reset
REQ-031 rst=1 SHALL immediately force:
  - state IDLE; launch, busy, resp_valid, resp_bit = 0;
  - LFSR/challenge = all-ones; counters and synchronizer = 0.
REQ-032 rst asserted mid-evaluation SHALL drop launch asynchronously with no response produced. After release, the block SHALL wait in IDLE for start.

Verification
REQ-033 Reset, then start pulse, defaults -> challenge = all-ones; launch high 9 cycles and low 8 cycles, repeated 15 times; resp_valid exactly 256 cycles after the start edge.
REQ-034 arb_resp=1 on 8 of 15 samples -> resp_bit=1. On 7 of 15 samples -> resp_bit=0.
REQ-035 seed_load with seed=64'h1 in IDLE, full evaluation plus handshake -> challenge = 64'h2. seed=0 -> challenge = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-036 resp_ready held low 20 cycles in DONE -> resp_valid, resp_bit and challenge stable throughout. Ready high -> IDLE next cycle, busy=0.
REQ-037 rst pulsed during the 5th FIRE -> launch=0 in the same cycle, resp_valid never asserts. Next start runs a full 256-cycle evaluation.
REQ-038 seed_load and start high in the same IDLE cycle -> seed loaded, no evaluation starts, busy stays 0.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: drives an LFSR challenge, fires the delay
// line VOTES times, and majority-votes the synchronized arbiter result.
module puf_eval_ctrl #(
  parameter int line_length   = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int VOTES         = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [line_length-1:0] seed,
  input  logic                   seed_load,
  input  logic                   start,
  input  logic                   arb_resp,
  output logic [line_length-1:0] challenge,
  output logic                   launch,
  output logic                   busy,
  output logic                   resp_valid,
  output logic                   resp_bit,
  input  logic                   resp_ready
);

  typedef enum logic [2:0] {IDLE, FIRE, SAMPLE, REST, DONE} state_t;

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SETTLE_CYCLES - 1);

  // Feedback tap bit positions (zero-based) for the two supported widths.
  localparam int T0 = line_length - 1;
  localparam int T1 = (line_length == 64) ? 62 : 21;
  localparam int T2 = (line_length == 64) ? 60 : 1;
  localparam int T3 = (line_length == 64) ? 59 : 0;

  state_t state, state_next;
  logic [CW-1:0] dwell, dwell_next;
  logic [7:0] votes_done, votes_next;
  logic [7:0] ones, ones_next;
  logic [line_length-1:0] lfsr, lfsr_next;
  logic launch_next, busy_next, valid_next, bit_next;
  logic arb_meta, arb_sync;
  logic handshake;

  assign challenge = lfsr;
  assign handshake = resp_valid & resp_ready;

  // arb_resp comes straight from an analog race, so it is double-flopped first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_meta <= 1'b0;
      arb_sync <= 1'b0;
    end else begin
      arb_meta <= arb_resp;
      arb_sync <= arb_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dwell      <= '0;
      votes_done <= '0;
      ones       <= '0;
      lfsr       <= '1;
      launch     <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_bit   <= 1'b0;
    end else begin
      state      <= state_next;
      dwell      <= dwell_next;
      votes_done <= votes_next;
      ones       <= ones_next;
      lfsr       <= lfsr_next;
      launch     <= launch_next;
      busy       <= busy_next;
      resp_valid <= valid_next;
      resp_bit   <= bit_next;
    end
  end

  always_comb begin
    state_next = state;
    dwell_next = dwell;
    votes_next = votes_done;
    ones_next  = ones;
    lfsr_next  = lfsr;
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_next = (seed == '0) ? '1 : seed;
        end else if (start) begin
          state_next = FIRE;
          dwell_next = '0;
          votes_next = '0;
          ones_next  = '0;
        end
      end
      FIRE: begin
        if (dwell == DWELL_LAST) begin
          state_next = SAMPLE;
          dwell_next = '0;
        end else begin
          dwell_next = dwell + 1'b1;
        end
      end
      SAMPLE: begin
        ones_next  = ones + {7'b0, arb_sync};
        votes_next = votes_done + 8'd1;
        state_next = REST;
      end
      REST: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          state_next = (votes_done < 8'(VOTES)) ? FIRE : DONE;
        end else begin
          dwell_next = dwell + 1'b1;
        end
      end
      DONE: begin
        if (handshake) begin
          state_next = IDLE;
          lfsr_next  = {lfsr[line_length-2:0], lfsr[T0] ^ lfsr[T1] ^ lfsr[T2] ^ lfsr[T3]};
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the next state, except the response, which
    // is decided one cycle into DONE once the final vote has been tallied.
    launch_next = (state_next == FIRE) || (state_next == SAMPLE);
    busy_next   = (state_next != IDLE);
    valid_next  = (state == DONE) && !handshake;
    bit_next    = resp_bit;
    if (state == DONE && !resp_valid) bit_next = (ones > 8'(VOTES / 2));
    if (handshake) bit_next = 1'b0;
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: random vote patterns against a
// majority/timing/LFSR reference model, plus seed, reset and handshake cases.
module tb_puf_eval_ctrl;

  localparam int LL = 64;
  localparam int SC = 8;
  localparam int NV = 15;
  localparam int PERIOD = 2 * SC + 1;
  localparam int LAT = 1 + NV * PERIOD;

  logic clk, rst, seed_load, start, arbResp, respReady;
  logic [LL-1:0] seed, challenge;
  logic launch, busy, respValid, respBit;

  int checks = 0;
  int errors = 0;
  logic [LL-1:0] expCh;

  puf_eval_ctrl #(.line_length(LL), .SETTLE_CYCLES(SC), .VOTES(NV)) dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load), .start(start),
    .arb_resp(arbResp), .challenge(challenge), .launch(launch), .busy(busy),
    .resp_valid(respValid), .resp_bit(respBit), .resp_ready(respReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: shift left, new bit 0 is the parity of the tapped bits.
  function automatic logic [63:0] lfsrModel(input logic [63:0] s);
    int taps[4] = '{64, 63, 61, 60};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i] - 1];
    return (s << 1) | {63'b0, fb};
  endfunction

  function automatic logic [14:0] patternWithOnes(input int n);
    logic [14:0] p = '0;
    int placed = 0;
    while (placed < n) begin
      int k = $urandom_range(0, 14);
      if (!p[k]) begin
        p[k] = 1'b1;
        placed++;
      end
    end
    return p;
  endfunction

  // One full evaluation: arbiter value held steady for each vote period,
  // launch pattern and latency checked, then a delayed handshake.
  task automatic applyStimulus(input logic [14:0] votes, input int holdCycles, input string name);
    int t;
    logic expBit;
    expBit = ($countones(votes) > NV / 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!respValid && t < LAT + 40) begin
      if (t % PERIOD == 0 && t / PERIOD < NV) arbResp = votes[t / PERIOD];
      checkOutput({name, " launch"}, launch, (t < LAT - 1) && (t % PERIOD < SC + 1));
      checkOutput({name, " busy"}, busy, 1'b1);
      checkOutput({name, " challenge"}, challenge, expCh);
      tick();
      t++;
    end
    checkOutput({name, " latency"}, t, LAT);
    start = (holdCycles > 0);
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput({name, " hold valid"}, respValid, 1'b1);
      checkOutput({name, " hold bit"}, respBit, expBit);
      checkOutput({name, " hold challenge"}, challenge, expCh);
      tick();
    end
    checkOutput({name, " resp_bit"}, respBit, expBit);
    start = 1'b0;
    respReady = 1'b1;
    tick();
    respReady = 1'b0;
    expCh = lfsrModel(expCh);
    checkOutput({name, " post valid"}, respValid, 1'b0);
    checkOutput({name, " post busy"}, busy, 1'b0);
    checkOutput({name, " post challenge"}, challenge, expCh);
    tick();
    checkOutput({name, " idle busy"}, busy, 1'b0);
    checkOutput({name, " idle launch"}, launch, 1'b0);
  endtask

  initial begin
    logic [63:0] rndSeed;
    rst = 1'b1;
    seed = '0;
    seed_load = 1'b0;
    start = 1'b0;
    arbResp = 1'b0;
    respReady = 1'b0;
    tick();
    tick();
    checkOutput("reset launch", launch, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset valid", respValid, 1'b0);
    checkOutput("reset bit", respBit, 1'b0);
    checkOutput("reset challenge", challenge, {LL{1'b1}});
    rst = 1'b0;
    tick();
    expCh = {LL{1'b1}};

    applyStimulus(patternWithOnes(8), 20, "eight ones");
    applyStimulus(patternWithOnes(7), 3, "seven ones");
    applyStimulus(15'($urandom), $urandom_range(0, 5), "random a");

    seed = 64'h1;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    expCh = 64'h1;
    checkOutput("seed one load", challenge, 64'h1);
    applyStimulus(15'($urandom), 2, "seed one");
    checkOutput("seed one advance", challenge, 64'h2);

    seed = '0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    expCh = {LL{1'b1}};
    checkOutput("zero seed", challenge, 64'hFFFF_FFFF_FFFF_FFFF);

    rndSeed = {$urandom, $urandom} | 64'h1;
    seed = rndSeed;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    expCh = rndSeed;
    checkOutput("load+start busy", busy, 1'b0);
    checkOutput("load+start challenge", challenge, rndSeed);
    tick();
    checkOutput("load+start busy later", busy, 1'b0);
    checkOutput("load+start launch", launch, 1'b0);
    applyStimulus(15'($urandom), 1, "random seed");

    // Reset during the fifth FIRE phase.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 * PERIOD + 2; i++) tick();
    checkOutput("pre-reset launch", launch, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset launch", launch, 1'b0);
    checkOutput("async reset busy", busy, 1'b0);
    checkOutput("async reset challenge", challenge, {LL{1'b1}});
    #1 rst = 1'b0;
    expCh = {LL{1'b1}};
    tick();
    for (int i = 0; i < LAT + 20; i++) begin
      checkOutput("after reset valid", respValid, 1'b0);
      checkOutput("after reset busy", busy, 1'b0);
      tick();
    end
    applyStimulus(15'($urandom), 4, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
